// File: rtl/serial_word_rx.sv
// serial_word_rx: start/8-data/even-parity/stop serial receiver with a
// one-word output register, valid/ready handshake and overrun pulse.
module serial_word_rx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             SDI,
    output logic [WIDTH-1:0] DATA,
    output logic             VALID,
    input  logic             READY,
    output logic             PERR,
    output logic             FERR,
    output logic             OVR
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic             sync1, line;
    logic             armed;
    logic             tick;
    logic             frame_done;
    logic [WIDTH-1:0] shreg;
    logic             perr_acc;

    // Two-flop synchronizer; idles high so reset looks like an idle line.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1 <= 1'b1;
            line  <= 1'b1;
        end else begin
            sync1 <= SDI;
            line  <= sync1;
        end
    end

    // Start detection is armed only after the line has been seen high, so a
    // line stuck low after a bad stop bit cannot fake a new start.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            armed <= 1'b0;
        end else if (frame_done && !line) begin
            armed <= 1'b0;
        end else if (line) begin
            armed <= 1'b1;
        end
    end

    // FSM state, bit-period counter and bit index registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic: sample the line when the counter reaches zero.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        frame_done = 1'b0;
        tick       = (state != S_IDLE) && (cnt == '0);
        case (state)
            S_IDLE: begin
                if (armed && !line) begin
                    state_nxt = S_START;
                    cnt_nxt   = CW'(DIV / 2 - 1);
                end
            end
            S_START: begin
                if (tick) begin
                    if (line) begin
                        state_nxt = S_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = S_DATA;
                        cnt_nxt   = CW'(DIV - 1);
                        idx_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    cnt_nxt = CW'(DIV - 1);
                    if (idx == IW'(WIDTH - 1)) begin
                        state_nxt = S_PARITY;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_nxt = S_STOP;
                    cnt_nxt   = CW'(DIV - 1);
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            S_STOP: begin
                if (tick) begin
                    state_nxt  = S_IDLE;
                    cnt_nxt    = '0;
                    frame_done = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Data capture into the shift register and parity check.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shreg    <= '0;
            perr_acc <= 1'b0;
        end else begin
            if (state == S_DATA && tick) begin
                shreg[idx] <= line;
            end
            if (state == S_PARITY && tick) begin
                perr_acc <= line ^ (^shreg);
            end
        end
    end

    // Output register: load on the stop sample unless an unconsumed word is
    // held, in which case the new word is dropped and OVR pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            DATA  <= '0;
            VALID <= 1'b0;
            PERR  <= 1'b0;
            FERR  <= 1'b0;
            OVR   <= 1'b0;
        end else begin
            OVR <= 1'b0;
            if (frame_done) begin
                if (!VALID || READY) begin
                    DATA  <= shreg;
                    PERR  <= perr_acc;
                    FERR  <= ~line;
                    VALID <= 1'b1;
                end else begin
                    OVR <= 1'b1;
                end
            end else if (VALID && READY) begin
                VALID <= 1'b0;
            end
        end
    end

endmodule
